// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns for hex digits 0..F,
// the all-off pattern, and the readback decoder's FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the digit-to-segment table: classifies an
// active-low pattern as a legal hex digit, the blank pattern, or illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic       o_legal,
  output logic       o_is_blank,
  output logic [3:0] o_digit
);

  always_comb begin
    o_legal    = 1'b1;
    o_is_blank = 1'b0;
    o_digit    = 4'h0;
    case (i_seg_n)
      SEG_0:     o_digit = 4'h0;
      SEG_1:     o_digit = 4'h1;
      SEG_2:     o_digit = 4'h2;
      SEG_3:     o_digit = 4'h3;
      SEG_4:     o_digit = 4'h4;
      SEG_5:     o_digit = 4'h5;
      SEG_6:     o_digit = 4'h6;
      SEG_7:     o_digit = 4'h7;
      SEG_8:     o_digit = 4'h8;
      SEG_9:     o_digit = 4'h9;
      SEG_A:     o_digit = 4'hA;
      SEG_B:     o_digit = 4'hB;
      SEG_C:     o_digit = 4'hC;
      SEG_D:     o_digit = 4'hD;
      SEG_E:     o_digit = 4'hE;
      SEG_F:     o_digit = 4'hF;
      SEG_BLANK: begin
        o_legal    = 1'b0;
        o_is_blank = 1'b1;
      end
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Reads back an active-low 7-segment pattern, accepts it once it has been
// stable for STABLE_CNT samples, and holds the recovered hex digit.
module seg7_readback_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 2,
  parameter int CHG_W      = 4
) (
  input  logic [1:0]       KEY,
  input  logic [6:0]       seg_n,
  output logic [3:0]       digit,
  output logic             valid,
  output logic             blank,
  output logic             err,
  output logic [CHG_W-1:0] changes,
  output logic [1:0]       state_o
);

  localparam logic [3:0] STAB = 4'(STABLE_CNT);

  logic             w_clk;
  logic             w_rst_n;
  logic             w_same;
  logic [3:0]       w_stab_next;
  logic             w_accept;
  logic             w_legal;
  logic             w_is_blank;
  logic [3:0]       w_dec_digit;

  logic [6:0]       r_seg_q;
  logic [3:0]       r_stab_cnt;
  state_t           r_state;
  logic [3:0]       r_digit;
  logic             r_valid;
  logic             r_blank;
  logic             r_err;
  logic [CHG_W-1:0] r_changes;

  assign w_clk   = KEY[0];
  assign w_rst_n = KEY[1];

  seg7_pattern_decode u_decode (
    .i_seg_n    (seg_n),
    .o_legal    (w_legal),
    .o_is_blank (w_is_blank),
    .o_digit    (w_dec_digit)
  );

  // Acceptance fires only on the edge the counter arrives at STABLE_CNT;
  // a saturated counter holding an unchanged pattern does not re-accept.
  assign w_same      = (seg_n == r_seg_q);
  assign w_stab_next = !w_same ? 4'd1 :
                       (r_stab_cnt == STAB) ? STAB : r_stab_cnt + 4'd1;
  assign w_accept    = (w_stab_next == STAB) && !(w_same && (r_stab_cnt == STAB));

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_seg_q    <= SEG_BLANK;
      r_stab_cnt <= 4'd0;
      r_state    <= EMPTY;
      r_digit    <= 4'h0;
      r_valid    <= 1'b0;
      r_blank    <= 1'b0;
      r_err      <= 1'b0;
      r_changes  <= '0;
    end else begin
      r_seg_q    <= seg_n;
      r_stab_cnt <= w_stab_next;
      if (w_accept) begin
        r_state <= LOCKED;
        if (w_legal) begin
          if (!r_valid || (w_dec_digit != r_digit))
            r_changes <= r_changes + CHG_W'(1);
          r_digit <= w_dec_digit;
          r_valid <= 1'b1;
          r_blank <= 1'b0;
        end else if (w_is_blank) begin
          r_valid <= 1'b0;
          r_blank <= 1'b1;
        end else begin
          r_err   <= 1'b1;
          r_valid <= 1'b0;
          r_blank <= 1'b0;
        end
      end else if (!w_same) begin
        r_state <= SETTLE;
      end
    end
  end

  assign digit   = r_digit;
  assign valid   = r_valid;
  assign blank   = r_blank;
  assign err     = r_err;
  assign changes = r_changes;
  assign state_o = r_state;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Scoreboard bench: two decoders (STABLE_CNT=2 and 1) share one stimulus
// stream; a run-length reference model predicts each edge's outputs.
module tb_seg7_readback_decoder;
  import seg7_pkg::*;

  typedef logic [12:0] obs_t;  // {digit, valid, blank, err, changes, state}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_n = 7'h7F;

  logic [3:0] digit0, digit1;
  logic       valid0, valid1, blank0, blank1, err0, err1;
  logic [3:0] changes0, changes1;
  logic [1:0] state0, state1;

  int n_cmp = 0;
  int n_bad = 0;

  obs_t q0[$];
  obs_t q1[$];

  // Reference table written out independently of the design package.
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [6:0] m_prev    [2];
  int         m_run     [2];
  logic [3:0] m_digit   [2];
  logic       m_valid   [2];
  logic       m_blank   [2];
  logic       m_err     [2];
  int         m_changes [2];
  logic [1:0] m_state   [2];

  always #5 clk = ~clk;

  seg7_readback_decoder #(.STABLE_CNT(2), .CHG_W(4)) u_dut2 (
    .KEY     ({rst_n, clk}),
    .seg_n   (seg_n),
    .digit   (digit0),
    .valid   (valid0),
    .blank   (blank0),
    .err     (err0),
    .changes (changes0),
    .state_o (state0)
  );

  seg7_readback_decoder #(.STABLE_CNT(1), .CHG_W(4)) u_dut1 (
    .KEY     ({rst_n, clk}),
    .seg_n   (seg_n),
    .digit   (digit1),
    .valid   (valid1),
    .blank   (blank1),
    .err     (err1),
    .changes (changes1),
    .state_o (state1)
  );

  function automatic obs_t m_obs(input int k);
    return {m_digit[k], m_valid[k], m_blank[k], m_err[k], 4'(m_changes[k]), m_state[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prev[k]    = 7'h7F;
      m_run[k]     = 0;
      m_digit[k]   = 4'h0;
      m_valid[k]   = 1'b0;
      m_blank[k]   = 1'b0;
      m_err[k]     = 1'b0;
      m_changes[k] = 0;
      m_state[k]   = 2'd0;
    end
  endtask

  // A pattern is accepted when its run of identical samples is exactly s_cnt long.
  task automatic model_edge(input int k, input int s_cnt, input logic [6:0] s);
    bit changed;
    int idx;
    changed = (s != m_prev[k]);
    m_run[k] = changed ? 1 : m_run[k] + 1;
    if (m_run[k] > 100) m_run[k] = 100;
    m_prev[k] = s;
    if (m_run[k] == s_cnt) begin
      idx = -1;
      for (int i = 0; i < 16; i++) if (tbl[i] == s) idx = i;
      m_state[k] = 2'd2;
      if (idx >= 0) begin
        if (!m_valid[k] || m_digit[k] != 4'(idx)) m_changes[k] = (m_changes[k] + 1) % 16;
        m_digit[k] = 4'(idx);
        m_valid[k] = 1'b1;
        m_blank[k] = 1'b0;
      end else if (s == 7'h7F) begin
        m_valid[k] = 1'b0;
        m_blank[k] = 1'b1;
      end else begin
        m_err[k]   = 1'b1;
        m_valid[k] = 1'b0;
        m_blank[k] = 1'b0;
      end
    end else if (changed) begin
      m_state[k] = 2'd1;
    end
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s seg=%h: got digit=%h valid=%b blank=%b err=%b changes=%0d state=%0d, want digit=%h valid=%b blank=%b err=%b changes=%0d state=%0d",
               name, seg_n, act[12:9], act[8], act[7], act[6], act[5:2], act[1:0],
               exp[12:9], exp[8], exp[7], exp[6], exp[5:2], exp[1:0]);
    end else begin
      $display("[%0t] %s seg=%h digit=%h valid=%b blank=%b err=%b changes=%0d state=%0d",
               $time, name, seg_n, act[12:9], act[8], act[7], act[6], act[5:2], act[1:0]);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      compare("edge_sc2", {digit0, valid0, blank0, err0, changes0, state0}, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      compare("edge_sc1", {digit1, valid1, blank1, err1, changes1, state1}, e);
    end
  end

  task automatic step(input logic [6:0] s);
    seg_n = s;
    @(posedge clk);
    model_edge(0, 2, s);
    model_edge(1, 1, s);
    q0.push_back(m_obs(0));
    q1.push_back(m_obs(1));
    #1;
  endtask

  task automatic hold(input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  // Reset is asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare("async_rst_sc2", {digit0, valid0, blank0, err0, changes0, state0}, m_obs(0));
    compare("async_rst_sc1", {digit1, valid1, blank1, err1, changes1, state1}, m_obs(1));
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int kind;
    logic [6:0] pat;
    model_reset();
    do_reset();

    // Basic acquire of digit 1, then reset while locked.
    hold(7'h79, 3);
    do_reset();

    // Toggling never stabilises for STABLE_CNT=2.
    for (int i = 0; i < 6; i++) step(i % 2 ? 7'h79 : 7'h40);
    do_reset();

    // Repeated 0 does not count; 0 then 2.
    hold(7'h40, 3);
    hold(7'h40, 3);
    hold(7'h24, 3);

    // Blank, illegal, then legal F: err stays sticky.
    hold(7'h7F, 3);
    hold(7'h55, 3);
    hold(7'h0E, 3);
    do_reset();

    // Sixteen distinct accepted digits wrap the 4-bit change counter.
    for (int i = 0; i < 16; i++) hold(tbl[i], 2);
    do_reset();

    // Single-sample acceptance on the fast instance.
    hold(7'h0E, 2);

    // Randomised mix of legal, blank and arbitrary patterns with random holds.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 5));
      if (kind <= 3)      pat = tbl[$urandom_range(0, 15)];
      else if (kind == 4) pat = 7'h7F;
      else                pat = 7'($urandom);
      hold(pat, int'($urandom_range(1, 3)));
      if (i == 30) do_reset();
    end

    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
